// File: rtl/balun_lpf_mc_if.sv
// Sample-in / filtered-sample-out stream pair for balun_lpf_mc.
// Both directions use valid/ready; the slave modport is the filter side.
interface balun_lpf_mc_if #(
  parameter int WIDTH = 16,
  parameter int CHW   = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CHW-1:0]          in_ch;
  logic signed [WIDTH-1:0] in_p;
  logic signed [WIDTH-1:0] in_n;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [CHW-1:0]          out_ch;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_settled;

  modport master (
    output in_valid, in_ch, in_p, in_n, in_mode, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_settled
  );

  modport slave (
    input  in_valid, in_ch, in_p, in_n, in_mode, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_settled
  );
endinterface

// File: rtl/balun_lpf_mc.sv
// Per-sample balun (DIFF/CM/SE) feeding a per-channel TAPS-deep moving average.
// Two-stage pipeline, one sample/cycle; a stalled output freezes both stages and in_ready drops.
module balun_lpf_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int TAPS     = 4
) (
  input logic           clk,
  input logic           rst,
  balun_lpf_mc_if.slave bus
);
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LOG2T = $clog2(TAPS);
  localparam int SW    = WIDTH + LOG2T;
  localparam logic [CHW:0]   CH_LIM = (CHW+1)'(CHANNELS);
  localparam logic [LOG2T:0] FULL   = (LOG2T+1)'(TAPS);

  logic                    w_stall;
  logic signed [WIDTH:0]   w_p_ext;
  logic signed [WIDTH:0]   w_n_ext;
  logic signed [WIDTH-1:0] w_b;

  logic                    r_s1_vld;
  logic                    r_s1_drop;
  logic [CHW-1:0]          r_s1_ch;
  logic signed [WIDTH-1:0] r_s1_b;

  logic signed [WIDTH-1:0] r_hist [CHANNELS][TAPS];
  logic signed [SW-1:0]    r_sum  [CHANNELS];
  logic [LOG2T-1:0]        r_ptr  [CHANNELS];
  logic [LOG2T:0]          r_fill [CHANNELS];

  logic                    r_out_valid;
  logic                    r_out_settled;
  logic [CHW-1:0]          r_out_ch;
  logic signed [WIDTH-1:0] r_out_data;

  logic [CHW-1:0]          w_ch;
  logic signed [WIDTH-1:0] w_old;
  logic signed [SW-1:0]    w_sum_nxt;
  logic [LOG2T:0]          w_fill_nxt;
  logic                    w_upd;

  assign w_stall      = r_out_valid & ~bus.out_ready;
  assign bus.in_ready = rst | ~w_stall;

  // One extra bit keeps p+n / p-n exact before the halving shift.
  always_comb begin
    w_p_ext = {bus.in_p[WIDTH-1], bus.in_p};
    w_n_ext = {bus.in_n[WIDTH-1], bus.in_n};
    w_b     = '0;
    case (bus.in_mode)
      2'b01:   w_b = WIDTH'((w_p_ext + w_n_ext) >>> 1);
      2'b10:   w_b = bus.in_p;
      default: w_b = WIDTH'((w_p_ext - w_n_ext) >>> 1);
    endcase
  end

  // Dropped samples steer the state read to channel 0; the result is discarded.
  always_comb begin
    w_ch       = r_s1_drop ? '0 : r_s1_ch;
    w_old      = r_hist[w_ch][r_ptr[w_ch]];
    w_sum_nxt  = r_sum[w_ch] - SW'(w_old) + SW'(r_s1_b);
    w_fill_nxt = (r_fill[w_ch] == FULL) ? FULL : r_fill[w_ch] + 1'b1;
    w_upd      = r_s1_vld & ~r_s1_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld      <= 1'b0;
      r_s1_drop     <= 1'b0;
      r_s1_ch       <= '0;
      r_s1_b        <= '0;
      r_out_valid   <= 1'b0;
      r_out_settled <= 1'b0;
      r_out_ch      <= '0;
      r_out_data    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_sum[c]  <= '0;
        r_ptr[c]  <= '0;
        r_fill[c] <= '0;
        for (int t = 0; t < TAPS; t++) r_hist[c][t] <= '0;
      end
    end else if (!w_stall) begin
      r_s1_vld    <= bus.in_valid;
      r_s1_drop   <= ({1'b0, bus.in_ch} >= CH_LIM);
      r_s1_ch     <= bus.in_ch;
      r_s1_b      <= w_b;
      r_out_valid <= w_upd;
      if (w_upd) begin
        r_hist[w_ch][r_ptr[w_ch]] <= r_s1_b;
        r_sum[w_ch]               <= w_sum_nxt;
        r_ptr[w_ch]               <= r_ptr[w_ch] + 1'b1;
        r_fill[w_ch]              <= w_fill_nxt;
        r_out_ch                  <= r_s1_ch;
        r_out_data                <= WIDTH'(w_sum_nxt >>> LOG2T);
        r_out_settled             <= (w_fill_nxt == FULL);
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_ch      = r_out_ch;
  assign bus.out_data    = r_out_data;
  assign bus.out_settled = r_out_settled;
endmodule

// File: tb/tb_balun_lpf_mc.sv
// Directed and randomized bench for balun_lpf_mc against a per-channel sample-history model.
module tb_balun_lpf_mc;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 3;
  localparam int TAPS     = 4;
  localparam int CHW      = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  balun_lpf_mc_if #(.WIDTH(WIDTH), .CHW(CHW)) bus ();

  balun_lpf_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .TAPS(TAPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic int balun(input int p, input int n, input int mode);
    if (mode == 1) return fdiv(p + n, 2);
    if (mode == 2) return p;
    return fdiv(p - n, 2);
  endfunction

  typedef struct {
    int ch;
    int data;
    bit settled;
  } exp_t;

  exp_t exp_q[$];
  int   chist[CHANNELS][$];
  int   log_data[$];
  int   log_ch[$];
  bit   log_set[$];

  bit   prev_rst = 1'b0;
  bit   prev_hold = 1'b0;
  int   prev_data;
  int   prev_ch;
  bit   prev_set;

  // Model: each channel keeps its last TAPS b values; missing entries count as zero.
  always @(negedge clk) begin
    if (prev_rst) begin
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_data", int'($signed(bus.out_data)), 0);
      chk("reset_out_ch", int'(bus.out_ch), 0);
      chk("reset_out_settled", int'(bus.out_settled), 0);
    end
    chk("in_ready", int'(bus.in_ready), int'(rst || !(bus.out_valid && !bus.out_ready)));
    if (prev_hold && !prev_rst) begin
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_data", int'($signed(bus.out_data)), prev_data);
      chk("hold_ch", int'(bus.out_ch), prev_ch);
      chk("hold_settled", int'(bus.out_settled), int'(prev_set));
    end
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < CHANNELS; c++) chist[c].delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_ch", int'(bus.out_ch), e.ch);
          chk("out_data", int'($signed(bus.out_data)), e.data);
          chk("out_settled", int'(bus.out_settled), int'(e.settled));
        end
        log_data.push_back(int'($signed(bus.out_data)));
        log_ch.push_back(int'(bus.out_ch));
        log_set.push_back(bus.out_settled);
      end
      if (bus.in_valid && bus.in_ready && int'(bus.in_ch) < CHANNELS) begin
        int c, s;
        exp_t e;
        c = int'(bus.in_ch);
        chist[c].push_back(balun(int'($signed(bus.in_p)), int'($signed(bus.in_n)), int'(bus.in_mode)));
        if (chist[c].size() > TAPS) void'(chist[c].pop_front());
        s = 0;
        for (int i = 0; i < chist[c].size(); i++) s += chist[c][i];
        e.ch      = c;
        e.data    = fdiv(s, TAPS);
        e.settled = (chist[c].size() == TAPS);
        exp_q.push_back(e);
      end
    end
    prev_rst  = rst;
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_data = int'($signed(bus.out_data));
    prev_ch   = int'(bus.out_ch);
    prev_set  = bus.out_settled;
  end

  task automatic clear_log();
    log_data.delete();
    log_ch.delete();
    log_set.delete();
  endtask

  task automatic send(input int ch, input int p, input int n, input int mode);
    int g;
    bus.in_valid = 1'b1;
    bus.in_ch    = ch[CHW-1:0];
    bus.in_p     = p[WIDTH-1:0];
    bus.in_n     = n[WIDTH-1:0];
    bus.in_mode  = mode[1:0];
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic chk_log(input string name, input int idx, input int exp);
    if (idx < log_data.size()) chk(name, log_data[idx], exp);
    else chk({name, "_missing"}, log_data.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_p      = '0;
    bus.in_n      = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();

    // Ramp with exact two-edge latency.
    send(0, 100, -100, 0);
    chk("lat_s1_valid", int'(bus.out_valid), 0);
    send(0, 100, -100, 0);
    chk("lat_s2_valid", int'(bus.out_valid), 1);
    chk("lat_s2_data", int'($signed(bus.out_data)), 25);
    send(0, 100, -100, 0);
    send(0, 100, -100, 0);
    idle(4);
    chk("ramp_count", log_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk_log("ramp_data", i, 25 * (i + 1));
      if (i < log_set.size()) chk("ramp_settled", int'(log_set[i]), int'(i == 3));
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(0, 40, -40, 0);
      send(1, -8, 0, 2);
    end
    idle(4);
    for (int i = 0; i < 4; i++) begin
      chk_log("ilv_ch0", 2 * i, 10 * (i + 1));
      chk_log("ilv_ch1", 2 * i + 1, -2 * (i + 1));
    end

    do_reset();
    for (int i = 0; i < 4; i++) send(0, 32767, -32768, 0);
    for (int i = 0; i < 4; i++) send(0, -32768, 32767, 0);
    idle(4);
    chk_log("ext_first", 0, 8191);
    chk_log("ext_pos", 3, 32767);
    chk_log("ext_neg", 7, -32768);

    do_reset();
    for (int i = 0; i < 4; i++) send(0, 10, 30, 1);
    idle(4);
    chk_log("mode_cm", 3, 20);
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 6, 2, 3);
    idle(4);
    chk_log("mode_11", 3, 2);

    do_reset();
    send(3, 500, -500, 0);
    send(2, 100, -100, 0);
    idle(4);
    chk("drop_count", log_data.size(), 1);
    chk_log("drop_next", 0, 25);
    if (log_ch.size() > 0) chk("drop_ch", log_ch[0], 2);

    do_reset();
    send(0, 100, -100, 0);
    send(0, 100, -100, 0);
    do_reset();
    send(0, 100, -100, 0);
    idle(4);
    chk("rstmid_count", log_data.size(), 1);
    chk_log("rstmid_data", 0, 25);
    if (log_set.size() > 0) chk("rstmid_settled", int'(log_set[0]), 0);

    do_reset();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int r;
          bus.in_valid = ($urandom % 4) != 0;
          bus.in_ch    = CHW'($urandom % 4);
          bus.in_mode  = 2'($urandom % 4);
          r = $urandom % 8;
          bus.in_p = (r == 0) ? 16'sh7fff : (r == 1) ? 16'sh8000 : WIDTH'($urandom);
          r = $urandom % 8;
          bus.in_n = (r == 0) ? 16'sh7fff : (r == 1) ? 16'sh8000 : WIDTH'($urandom);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int j = 0; j < 400; j++) begin
          bus.out_ready = (j >= 100 && j < 105) ? 1'b0 : (($urandom % 4) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(8);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
